config_bitstream_loader: RTL

Transmit-side driver for the configuration shift-register chain. It accepts parallel configuration words over a valid/ready handshake and serializes them into the chain's serial data and shift-enable inputs, one bit per cycle. It stops after exactly CHAIN_LENGTH shifts and then reports done. It sits between the bitstream source (host interface or boot ROM reader) and the head of the fabric's config chain.

---
 rtl/config_loader_pkg.sv | 17 +
 rtl/config_bitstream_loader_crc8_serial.sv | 28 ++
 rtl/config_bitstream_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
// The CHECK state and the CRC constants are only used when
// CONFIG_LOADER_CRC_EN is defined.
package config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/config_bitstream_loader_crc8_serial.sv
// Bit-serial CRC-8, polynomial x^8+x^2+x+1, non-reflected.
// It absorbs one bit per cycle while bit_valid is high.
// clear restarts the CRC from CRC8_INIT.
module crc8_serial
    import config_loader_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic       clear,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic feedback;

    assign feedback = crc[7] ^ bit_in;

    // Galois-form LFSR update, one message bit per valid cycle
    always_ff @(posedge clock) begin
        if (!nreset || clear) begin
            crc <= CRC8_INIT;
        end else if (bit_valid) begin
            crc <= {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/config_bitstream_loader.sv
// Serializes parallel configuration words into the config shift chain,
// MSB first, one bit per cycle, and stops after CHAIN_LENGTH shifts.
// Optional macro CONFIG_LOADER_CRC_EN adds a CRC-8 check word after the
// last chain bit.
//
// Handshake: a word transfers on a rising edge where word_valid=1 and
// word_ready=1. word_ready is registered and is high only in FETCH (and
// CHECK with the CRC build). The source may present data at any time, and
// may withdraw it at any time. Nothing is consumed while word_ready=0.
//
// The FSM state is visible as the internal signal `state` for checkers.
module config_bitstream_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 64,
    parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  cfg_data,
    output logic                  cfg_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int WB_WIDTH = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CHAIN_LAST = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [WB_WIDTH-1:0]  WORD_LAST  = WB_WIDTH'(WORD_WIDTH);

    loader_state_t         state, state_nxt;
    logic [CNT_WIDTH-1:0]  bit_cnt, bit_cnt_nxt;
    logic [WB_WIDTH-1:0]   word_cnt, word_cnt_nxt;
    logic [WORD_WIDTH-1:0] sreg, sreg_nxt;
    logic                  cfg_data_nxt;

`ifdef CONFIG_LOADER_CRC_EN
    logic       error_nxt;
    logic       crc_clear;
    logic       crc_shift;
    logic [7:0] crc;

    // cfg_data is the bit on the chain during a SHIFT cycle, so the CRC
    // sees exactly the bits the chain receives, in the same order
    crc8_serial u_crc (
        .clock     (clock),
        .nreset    (nreset),
        .clear     (crc_clear),
        .bit_valid (crc_shift),
        .bit_in    (cfg_data),
        .crc       (crc)
    );
`endif

    // Next-state, counter and shift-buffer logic
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        sreg_nxt     = sreg;
        cfg_data_nxt = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        error_nxt    = error;
        crc_clear    = 1'b0;
        crc_shift    = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = FETCH;
                    bit_cnt_nxt = '0;
`ifdef CONFIG_LOADER_CRC_EN
                    error_nxt   = 1'b0;
                    crc_clear   = 1'b1;
`endif
                end
            end
            FETCH: begin
                if (word_valid && word_ready) begin
                    state_nxt    = SHIFT;
                    sreg_nxt     = word_data;
                    word_cnt_nxt = '0;
                    cfg_data_nxt = word_data[WORD_WIDTH-1];
                end
            end
            SHIFT: begin
`ifdef CONFIG_LOADER_CRC_EN
                crc_shift    = 1'b1;
`endif
                bit_cnt_nxt  = bit_cnt + CNT_WIDTH'(1);
                word_cnt_nxt = word_cnt + WB_WIDTH'(1);
                // The chain length wins over the word boundary, so a short
                // final word drops its unshifted low bits
                if (bit_cnt_nxt == CHAIN_LAST) begin
`ifdef CONFIG_LOADER_CRC_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end else if (word_cnt_nxt == WORD_LAST) begin
                    state_nxt = FETCH;
                end else begin
                    sreg_nxt     = sreg << 1;
                    cfg_data_nxt = sreg_nxt[WORD_WIDTH-1];
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            CHECK: begin
                if (word_valid && word_ready) begin
                    state_nxt = DONE;
                    error_nxt = (word_data[7:0] != crc);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            sreg       <= '0;
            word_ready <= 1'b0;
            cfg_data   <= 1'b0;
            cfg_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
            sreg       <= sreg_nxt;
            word_ready <= (state_nxt == FETCH) || (state_nxt == CHECK);
            cfg_data   <= cfg_data_nxt;
            cfg_enable <= (state_nxt == SHIFT);
            busy       <= (state_nxt == FETCH) || (state_nxt == SHIFT) ||
                          (state_nxt == CHECK);
            done       <= (state_nxt == DONE);
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    // CRC verdict, cleared by an accepted start
    always_ff @(posedge clock) begin
        if (!nreset) begin
            error <= 1'b0;
        end else begin
            error <= error_nxt;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule
